inference_request_ingress_arbiter: RTL

INFERENCE_REQUEST_INGRESS_ARBITER -- requirements
Module: inference_request_ingress_arbiter

---
 rtl/inference_request_ingress_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/inference_request_ingress_arbiter.sv
// rtl/inference_request_ingress_arbiter.sv - packet-locked round-robin ingress arbiter feeding the packet parser
// Optional INFERENCE_ARB_PORT_TAG_EN stamps grant_port into the top byte of m_axis_tuser.
module inference_request_ingress_arbiter #(
    parameter  int TDATA_WIDTH    = 256,
    parameter  int TUSER_WIDTH    = 128,
    parameter  int NUM_PORTS      = 4,
    localparam int TKEEP_WIDTH    = TDATA_WIDTH / 8,
    localparam int PORT_IDX_WIDTH = 3
) (
    input  logic                             axis_aclk,
    input  logic                             axis_reset,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic [PORT_IDX_WIDTH-1:0]        grant_port,
    output logic                             busy,
    output logic [31:0]                      packets_forwarded
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PORT_IDX_WIDTH-1:0] r_grant_port;
    logic [PORT_IDX_WIDTH-1:0] r_rr_ptr;
    logic [PORT_IDX_WIDTH-1:0] w_req_idx;
    logic [31:0]               r_pkt_cnt;
    logic                      w_req_found;
    logic [7:0]                w_valid_ext;
    logic [7:0]                w_tready_ext;
    logic [PORT_IDX_WIDTH:0]   w_scan;
    logic                      w_sel_valid;
    logic                      w_sel_last;
    logic                      w_fire_last;

    // Scan offsets from farthest to nearest so the port closest to rr_ptr wins.
    always_comb begin
        w_valid_ext                = '0;
        w_valid_ext[NUM_PORTS-1:0] = s_axis_tvalid;
        w_req_found                = 1'b0;
        w_req_idx                  = r_rr_ptr;
        w_scan                     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + 4'(k);
            if (w_scan >= 4'(NUM_PORTS)) begin
                w_scan = w_scan - 4'(NUM_PORTS);
            end
            if (w_valid_ext[w_scan[PORT_IDX_WIDTH-1:0]]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_scan[PORT_IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tuser = '0;
        w_sel_valid  = 1'b0;
        w_sel_last   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant_port == PORT_IDX_WIDTH'(p)) begin
                m_axis_tdata = s_axis_tdata[p*TDATA_WIDTH +: TDATA_WIDTH];
                m_axis_tkeep = s_axis_tkeep[p*TKEEP_WIDTH +: TKEEP_WIDTH];
                m_axis_tuser = s_axis_tuser[p*TUSER_WIDTH +: TUSER_WIDTH];
                w_sel_valid  = s_axis_tvalid[p];
                w_sel_last   = s_axis_tlast[p];
            end
        end
`ifdef INFERENCE_ARB_PORT_TAG_EN
        m_axis_tuser[TUSER_WIDTH-1 -: 8] = 8'(r_grant_port);
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tready_ext  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        w_fire_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_found) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                m_axis_tvalid              = w_sel_valid;
                m_axis_tlast               = w_sel_last;
                w_tready_ext[r_grant_port] = m_axis_tready;
                w_fire_last                = w_sel_valid & m_axis_tready & w_sel_last;
                if (w_fire_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant_port <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_req_found) begin
                r_grant_port <= w_req_idx;
            end
            if (w_fire_last) begin
                r_rr_ptr  <= (r_grant_port == PORT_IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : r_grant_port + 3'd1;
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign s_axis_tready     = w_tready_ext[NUM_PORTS-1:0];
    assign grant_port        = r_grant_port;
    assign busy              = (r_state == ST_LOCKED);
    assign packets_forwarded = r_pkt_cnt;

endmodule
